// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: widths, base opcodes, immediate formats and the
// ID/EX pipeline register layout.
package rv32i_pkg;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [6:0] {
    LUI      = 7'b0110111,
    AUIPC    = 7'b0010111,
    JAL      = 7'b1101111,
    JALR     = 7'b1100111,
    BRANCH   = 7'b1100011,
    LOAD     = 7'b0000011,
    STORE    = 7'b0100011,
    OP_IMM   = 7'b0010011,
    OP       = 7'b0110011,
    MISC_MEM = 7'b0001111,
    SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  typedef struct packed {
    logic                      valid;
    logic [XLEN-1:0]           pc;
    logic [XLEN-1:0]           rs1_val;
    logic [XLEN-1:0]           rs2_val;
    logic [XLEN-1:0]           imm;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic                      is_load;
    logic                      wr_en;
    logic                      illegal;
  } idex_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: reassembles and sign-extends the
// immediate for the selected instruction format.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  // Opcode bits never contribute to an immediate.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^instr[6:0];

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: field split, immediate generation, operand fetch with
// writeback bypass, load-use stall and the ID/EX pipeline register.
module decode_stage
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [31:0]               id_instr,
  input  logic [XLEN-1:0]           id_pc,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr1,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr2,
  input  logic [XLEN-1:0]           rf_data1,
  input  logic [XLEN-1:0]           rf_data2,
  input  logic                      wb_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [XLEN-1:0]           wb_data,
  input  logic                      flush,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [XLEN-1:0]           ex_pc,
  output logic [XLEN-1:0]           ex_rs1_val,
  output logic [XLEN-1:0]           ex_rs2_val,
  output logic [XLEN-1:0]           ex_imm,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs1,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs2,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [6:0]                ex_opcode,
  output logic [2:0]                ex_funct3,
  output logic [6:0]                ex_funct7,
  output logic                      ex_is_load,
  output logic                      ex_wr_en,
  output logic                      ex_illegal
);

  idex_t ex_reg;
  idex_t ex_next;

  logic [6:0]                opcode;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [REG_ADDR_WIDTH-1:0] rs_idx  [2];
  logic [XLEN-1:0]           rf_data [2];
  logic [XLEN-1:0]           op_val  [2];
  logic [XLEN-1:0]           imm;

  imm_fmt_e imm_fmt;
  logic     rs1_used;
  logic     rs2_used;
  logic     writes_rd;
  logic     is_load;
  logic     illegal;
  logic     hazard;
  logic     adv;

  assign opcode    = id_instr[6:0];
  assign rd        = id_instr[11:7];
  assign rs_idx[0] = id_instr[19:15];
  assign rs_idx[1] = id_instr[24:20];
  assign rf_data[0] = rf_data1;
  assign rf_data[1] = rf_data2;
  assign rf_addr1  = rs_idx[0];
  assign rf_addr2  = rs_idx[1];

  // x0 reads as zero; a same-cycle writeback wins over the stale RF value.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      always_comb begin
        if (rs_idx[gi] == '0)
          op_val[gi] = '0;
        else if (wb_wr_en && (wb_addr == rs_idx[gi]))
          op_val[gi] = wb_data;
        else
          op_val[gi] = rf_data[gi];
      end
    end
  endgenerate

  always_comb begin
    imm_fmt   = IMM_NONE;
    rs1_used  = 1'b1;
    rs2_used  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      LUI:      begin imm_fmt = IMM_U; rs1_used = 1'b0; writes_rd = 1'b1; end
      AUIPC:    begin imm_fmt = IMM_U; rs1_used = 1'b0; writes_rd = 1'b1; end
      JAL:      begin imm_fmt = IMM_J; rs1_used = 1'b0; writes_rd = 1'b1; end
      JALR:     begin imm_fmt = IMM_I; writes_rd = 1'b1; end
      BRANCH:   begin imm_fmt = IMM_B; rs2_used = 1'b1; end
      LOAD:     begin imm_fmt = IMM_I; writes_rd = 1'b1; is_load = 1'b1; end
      STORE:    begin imm_fmt = IMM_S; rs2_used = 1'b1; end
      OP_IMM:   begin imm_fmt = IMM_I; writes_rd = 1'b1; end
      OP:       begin imm_fmt = IMM_NONE; rs2_used = 1'b1; writes_rd = 1'b1; end
      MISC_MEM: imm_fmt = IMM_I;
      SYSTEM:   imm_fmt = IMM_I;
      default:  illegal = 1'b1;
    endcase
  end

  imm_gen u_imm_gen (
    .instr (id_instr),
    .fmt   (imm_fmt),
    .imm   (imm)
  );

  assign hazard = ex_reg.valid && ex_reg.is_load && (ex_reg.rd != '0) &&
                  ((rs1_used && (rs_idx[0] == ex_reg.rd)) ||
                   (rs2_used && (rs_idx[1] == ex_reg.rd)));
  assign adv      = !ex_reg.valid || ex_ready;
  assign id_ready = flush || (adv && !hazard);

  always_comb begin
    ex_next = ex_reg;
    if (flush || (adv && (hazard || !id_valid))) begin
      ex_next.valid   = 1'b0;
      ex_next.wr_en   = 1'b0;
      ex_next.is_load = 1'b0;
    end else if (adv) begin
      ex_next.valid   = 1'b1;
      ex_next.pc      = id_pc;
      ex_next.rs1_val = op_val[0];
      ex_next.rs2_val = op_val[1];
      ex_next.imm     = imm;
      ex_next.rs1     = rs_idx[0];
      ex_next.rs2     = rs_idx[1];
      ex_next.rd      = rd;
      ex_next.opcode  = opcode;
      ex_next.funct3  = id_instr[14:12];
      ex_next.funct7  = id_instr[31:25];
      ex_next.is_load = is_load;
      ex_next.wr_en   = writes_rd && (rd != '0);
      ex_next.illegal = illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg    <= '0;
      ex_reg.pc <= RESET_PC;
    end else begin
      ex_reg <= ex_next;
    end
  end

  assign ex_valid   = ex_reg.valid;
  assign ex_pc      = ex_reg.pc;
  assign ex_rs1_val = ex_reg.rs1_val;
  assign ex_rs2_val = ex_reg.rs2_val;
  assign ex_imm     = ex_reg.imm;
  assign ex_rs1     = ex_reg.rs1;
  assign ex_rs2     = ex_reg.rs2;
  assign ex_rd      = ex_reg.rd;
  assign ex_opcode  = ex_reg.opcode;
  assign ex_funct3  = ex_reg.funct3;
  assign ex_funct7  = ex_reg.funct7;
  assign ex_is_load = ex_reg.is_load;
  assign ex_wr_en   = ex_reg.wr_en;
  assign ex_illegal = ex_reg.illegal;

endmodule
